// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory slave: FSM states, transfer direction
// encoding and the wait-state limit that sizes the wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } apb_state_e;

    localparam logic APB_READ  = 1'b0;
    localparam logic APB_WRITE = 1'b1;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = $clog2(WAIT_STATES_MAX + 1);

endpackage

// File: rtl/apb_mem_array.sv
// Word-organised storage with per-byte write enables and a registered read
// port. The read register is cleared by reset or by an explicit clear so the
// front-end can return zero for rejected reads. Storage itself is never reset.
module apb_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic                       rclr,
    input  logic [$clog2(DEPTH)-1:0]   idx,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic [DATA_WIDTH-1:0]      wdata,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    logic [BYTES-1:0][7:0] mem [DEPTH];

    // byte-lane writes; lanes with a clear strobe keep their old contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[idx][b] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // registered read; holds its value until the next read, clear or reset
    always_ff @(posedge clk) begin
        if (rst || rclr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB memory slave: transfer FSM, wait-state counter and address/error decode
// in front of apb_mem_array. The request is captured at the setup edge and
// held for the whole transfer; the memory commit and read happen on the edge
// that enters DONE, so PREADY, PSLVERR and PRDATA all appear together.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      READ_WRITE,
    input  logic [ADDR_WIDTH-1:0]     PADDR,
    input  logic [DATA_WIDTH-1:0]     PWDATA,
    input  logic [DATA_WIDTH/8-1:0]   PSTRB,
    output logic [DATA_WIDTH-1:0]     PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR
);

    localparam int          BYTES     = DATA_WIDTH / 8;
    localparam int          BOFF      = $clog2(BYTES);
    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH * BYTES);

    apb_state_e              state, state_nxt;
    logic [WAIT_CNT_W-1:0]   cnt, cnt_nxt;
    logic                    latch;
    logic                    setup_req;
    logic                    enter_done;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BYTES-1:0]        strb_q;

    logic                    err;
    logic                    mem_we, mem_re, mem_rclr;

    assign setup_req  = PSEL && !PENABLE;
    assign enter_done = (state_nxt == ST_DONE);

    // out of range or not word aligned; decoded from the held request only
    assign err = ((addr_q & ADDR_WIDTH'(BYTES - 1)) != '0) ||
                 (64'(addr_q) >= MEM_BYTES);

    // next-state and counter: setup edge loads the counter, WAIT counts down,
    // losing PSEL (or PENABLE during WAIT) abandons the transfer
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (setup_req) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
                    latch     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!PSEL) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!PSEL || !PENABLE) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == WAIT_CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (setup_req) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
                    latch     = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // state, counter and registered handshake outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            PREADY  <= enter_done;
            PSLVERR <= enter_done && err;
        end
    end

    // capture the request at the setup edge; bus changes afterwards are ignored
    always_ff @(posedge PCLK) begin
        if (!PRESET && latch) begin
            addr_q  <= PADDR;
            wr_q    <= READ_WRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // reset on the commit edge wins, so a cut-off write never lands
    assign mem_we   = !PRESET && enter_done && (wr_q == APB_WRITE) && !err;
    assign mem_re   = !PRESET && enter_done && (wr_q == APB_READ)  && !err;
    assign mem_rclr = !PRESET && enter_done && (wr_q == APB_READ)  &&  err;

    apb_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (mem_we),
        .re    (mem_re),
        .rclr  (mem_rclr),
        .idx   (addr_q[BOFF +: IDX_W]),
        .wstrb (strb_q),
        .wdata (wdata_q),
        .rdata (PRDATA)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: three instances with 0, 2 and 3 wait states run the
// same directed and random traffic in parallel. Each issued transfer pushes its
// expected response (DONE cycle, error flag, read data) computed from a plain
// byte-array memory model; a monitor pops and compares whenever PREADY is seen.
module tb_apb_mem_slave;

    localparam int NI = 3;
    localparam logic [NI-1:0][3:0] WSV = {4'd3, 4'd2, 4'd0};

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
        logic [31:0] mask;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        preset  [NI];
    logic        psel    [NI];
    logic        penable [NI];
    logic        rw      [NI];
    logic [31:0] paddr   [NI];
    logic [31:0] pwdata  [NI];
    logic [3:0]  pstrb   [NI];
    logic [31:0] prdata  [NI];
    logic        pready  [NI];
    logic        pslverr [NI];

    exp_t        sbq [NI][$];
    logic [31:0] mdl [NI][64];
    logic [3:0]  kb  [NI][64];
    logic [31:0] last_rd [NI];
    logic [31:0] last_mk [NI];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_mem_slave #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .DEPTH       (64),
            .WAIT_STATES (int'(WSV[g]))
        ) u_dut (
            .PCLK       (clk),
            .PRESET     (preset[g]),
            .PSEL       (psel[g]),
            .PENABLE    (penable[g]),
            .READ_WRITE (rw[g]),
            .PADDR      (paddr[g]),
            .PWDATA     (pwdata[g]),
            .PSTRB      (pstrb[g]),
            .PRDATA     (prdata[g]),
            .PREADY     (pready[g]),
            .PSLVERR    (pslverr[g])
        );
    end

    function automatic logic [31:0] bmask(logic [3:0] b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{b[i]}};
        return m;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", nm, k, cyc, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NI; k++) begin
            if (pready[k] === 1'b1) begin
                if (sbq[k].size() == 0) begin
                    chk("spurious_pready", k, 32'(pready[k]), 32'd0);
                end else begin
                    e = sbq[k].pop_front();
                    chk("done_cycle", k, 32'(cyc), 32'(e.cyc));
                    chk("pslverr", k, 32'(pslverr[k]), 32'(e.err));
                    if (e.mask != 32'd0)
                        chk("prdata", k, prdata[k] & e.mask, e.data & e.mask);
                end
            end
        end
    end

    task automatic check_reset_outputs(int k);
        chk("rst_pready", k, 32'(pready[k]), 32'd0);
        chk("rst_pslverr", k, 32'(pslverr[k]), 32'd0);
        chk("rst_prdata", k, prdata[k], 32'd0);
        last_rd[k] = 32'd0;
        last_mk[k] = 32'hFFFF_FFFF;
    endtask

    task automatic do_reset(int k);
        preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        preset[k] = 1'b0;
        @(negedge clk);
        check_reset_outputs(k);
        @(posedge clk); #1;
    endtask

    task automatic idle(int k);
        psel[k] = 1'b0; penable[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    // one full transfer; returns at the start of its DONE cycle so the caller
    // can either issue the next setup (back-to-back) or go idle
    task automatic issue(int k, bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        int   ws = int'(WSV[k]);
        exp_t e;
        bit   err;
        int   w;
        err = (a[1:0] != 2'b00) || (a >= 32'd256);
        w   = int'(a[7:2]);
        if (!wr) begin
            if (err) begin
                last_rd[k] = 32'd0; last_mk[k] = 32'hFFFF_FFFF;
            end else begin
                last_rd[k] = mdl[k][w]; last_mk[k] = bmask(kb[k][w]);
            end
        end else if (!err) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    mdl[k][w][b*8 +: 8] = d[b*8 +: 8];
                    kb[k][w][b] = 1'b1;
                end
            end
        end
        e.cyc = cyc + 2 + ws; e.err = err; e.data = last_rd[k]; e.mask = last_mk[k];
        sbq[k].push_back(e);
        psel[k] = 1'b1; penable[k] = 1'b0; rw[k] = wr;
        paddr[k] = a; pwdata[k] = d; pstrb[k] = s;
        repeat (1 + ws) begin
            @(posedge clk); #1;
            penable[k] = 1'b1;
            paddr[k] = $urandom; pwdata[k] = $urandom;
            pstrb[k] = 4'($urandom); rw[k] = 1'($urandom);
        end
        @(posedge clk); #1;
    endtask

    // transfer cut short j cycles after SETUP: mode 0 drops PSEL,
    // mode 1 drops PENABLE only, mode 2 asserts reset
    task automatic abort_xfer(int k, logic [31:0] a, logic [31:0] d, int j, int mode);
        psel[k] = 1'b1; penable[k] = 1'b0; rw[k] = 1'b1;
        paddr[k] = a; pwdata[k] = d; pstrb[k] = 4'hF;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        repeat (j) begin @(posedge clk); #1; end
        case (mode)
            0: psel[k] = 1'b0;
            1: penable[k] = 1'b0;
            default: preset[k] = 1'b1;
        endcase
        @(posedge clk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0; preset[k] = 1'b0;
        @(negedge clk);
        chk("abort_pready", k, 32'(pready[k]), 32'd0);
        if (mode == 2) check_reset_outputs(k);
        @(posedge clk); #1;
        chk("abort_pready2", k, 32'(pready[k]), 32'd0);
    endtask

    task automatic run_inst(int k);
        int          ws = int'(WSV[k]);
        int          jw = (ws == 0) ? 0 : 1;
        logic [31:0] a;
        do_reset(k);
        // basic write/read
        issue(k, 1, 32'h10, 32'hDEADBEEF, 4'hF); idle(k);
        issue(k, 0, 32'h10, $urandom, 4'h0); idle(k);
        // partial strobes, back-to-back
        issue(k, 1, 32'h20, 32'h11223344, 4'hF);
        issue(k, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
        issue(k, 0, 32'h20, 32'h0, 4'h0); idle(k);
        // three back-to-back writes, then readback
        issue(k, 1, 32'h0, 32'h0A0A0A0A, 4'hF);
        issue(k, 1, 32'h4, 32'h14141414, 4'hF);
        issue(k, 1, 32'h8, 32'h28282828, 4'hF);
        issue(k, 0, 32'h0, 32'h0, 4'h0);
        issue(k, 0, 32'h4, 32'h0, 4'h0);
        issue(k, 0, 32'h8, 32'h0, 4'h0); idle(k);
        // error responses; 0x100 aliases word 0 and 0x12 aliases word 4
        issue(k, 1, 32'h100, 32'h55555555, 4'hF); idle(k);
        issue(k, 1, 32'h12, 32'h66666666, 4'hF); idle(k);
        issue(k, 0, 32'h100, 32'h0, 4'h0);
        issue(k, 0, 32'h0, 32'h0, 4'h0);
        issue(k, 0, 32'h10, 32'h0, 4'h0); idle(k);
        // read with strobes set must not write
        issue(k, 0, 32'h4, 32'h99999999, 4'hF);
        issue(k, 0, 32'h4, 32'h0, 4'h0); idle(k);
        // aborted writes to 0x8 leave it unchanged
        abort_xfer(k, 32'h8, 32'hBAD0BAD0, jw, 0);
        issue(k, 0, 32'h8, 32'h0, 4'h0); idle(k);
        if (ws > 0) begin
            abort_xfer(k, 32'h8, 32'hBAD1BAD1, 1, 1);
            issue(k, 0, 32'h8, 32'h0, 4'h0); idle(k);
        end
        abort_xfer(k, 32'h8, 32'hBAD2BAD2, jw, 2);
        issue(k, 1, 32'h24, 32'h12345678, 4'hF);
        issue(k, 0, 32'h8, 32'h0, 4'h0);
        issue(k, 0, 32'h24, 32'h0, 4'h0); idle(k);
        // random traffic
        repeat (40) begin
            int r = $urandom_range(0, 9);
            a = {24'h0, 6'($urandom), 2'b00};
            if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (r == 1) a = a + 32'h100 * $urandom_range(1, 4);
            issue(k, 1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) idle(k);
        end
        idle(k);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            preset[k] = 1'b1; psel[k] = 1'b0; penable[k] = 1'b0; rw[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
            last_rd[k] = '0; last_mk[k] = '0;
            for (int w = 0; w < 64; w++) begin
                kb[k][w] = 4'h0; mdl[k][w] = '0;
            end
        end
        fork
            run_inst(0);
            run_inst(1);
            run_inst(2);
        join
        repeat (6) @(posedge clk);
        for (int k = 0; k < NI; k++) chk("sb_drained", k, 32'(sbq[k].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_mem_slave.md
APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, PADDR width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width, one of 8/16/32.
REQ-003 The block SHALL have parameter DEPTH, default 64, word count, power of two, at least 2.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, range 0..15, extra ACCESS cycles before PREADY.
REQ-005 The block SHALL have port PCLK, input, 1, sole clock; all state on rising edge.
REQ-006 The block SHALL have port PRESET, input, 1, reset; synchronous, active-high.
REQ-007 The block SHALL have port PSEL, input, 1, slave select.
REQ-008 The block SHALL have port PENABLE, input, 1, ACCESS-phase marker.
REQ-009 The block SHALL have port READ_WRITE, input, 1, 0 = read, 1 = write.
REQ-010 The block SHALL have port PADDR, input, ADDR_WIDTH, byte address.
REQ-011 The block SHALL have port PWDATA, input, DATA_WIDTH, write data.
REQ-012 The block SHALL have port PSTRB, input, DATA_WIDTH/8, byte write strobes.
REQ-013 The block SHALL have port PRDATA, output, DATA_WIDTH, read data, registered.
REQ-014 The block SHALL have port PREADY, output, 1, transfer complete, registered.
REQ-015 The block SHALL have port PSLVERR, output, 1, error response, valid only while PREADY=1, registered.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, WAIT, DONE; encoding is free.
REQ-017 IDLE→SETUP SHALL occur on an edge with PSEL=1, PENABLE=0; the block latches PADDR, READ_WRITE, PWDATA and PSTRB at that edge and loads the wait counter with WAIT_STATES.
REQ-018 SETUP SHALL go →DONE if the counter is 0, else →WAIT; WAIT SHALL decrement each edge and go →DONE when the counter reaches 0.
REQ-019 PREADY SHALL be 1 exactly in DONE; a transfer takes 2+WAIT_STATES cycles counted from the SETUP cycle.
REQ-020 Word index SHALL be the latched PADDR bits [log2(DATA_WIDTH/8) +: log2(DEPTH)].
REQ-021 Error SHALL be PADDR misaligned (low byte bits ≠ 0) or PADDR ≥ DEPTH·DATA_WIDTH/8; PSLVERR=1 in DONE when error.
REQ-022 A write without error SHALL update only the bytes with PSTRB set, committed on the edge entering DONE; an erroring write SHALL leave memory unchanged.
REQ-023 A read SHALL drive PRDATA with the word in DONE; an erroring read SHALL drive 0; PRDATA SHALL hold its last value outside DONE.
REQ-024 A read with PSTRB≠0 SHALL be ignored for strobes; memory is unaffected.
REQ-025 DONE→SETUP SHALL occur if PSEL=1, PENABLE=0 at that edge (back-to-back), else DONE→IDLE.
REQ-026 If PSEL=0 in SETUP or WAIT, the block SHALL abort to IDLE with no memory write, PREADY=0.
REQ-027 PENABLE=0 in WAIT with PSEL=1 SHALL be treated as a protocol violation: abort to IDLE, no write.
REQ-028 Latched address, data and strobes SHALL NOT change mid-transfer regardless of bus changes.

Reset
REQ-029 PRESET=1 at an edge SHALL force IDLE, PREADY=0, PSLVERR=0, PRDATA=0 and counter=0, overriding any transfer, including one in DONE.
REQ-030 Memory contents SHALL NOT be reset; reads of unwritten words return X in simulation.
REQ-031 An in-flight write cut by reset SHALL NOT commit unless the commit edge preceded reset.

Structure
REQ-032 Package apb_pkg SHALL hold the FSM state typedef, the READ/WRITE constants (0/1) and the WAIT_STATES maximum (15).
REQ-033 Sub-module apb_mem_array SHALL hold the DEPTH×DATA_WIDTH storage with per-byte write enable and a registered read port.
REQ-034 The FSM, counter and error decode SHALL remain in apb_mem_slave.

Verification
REQ-035 Defaults: write 0xDEADBEEF to 0x10, PSTRB=0xF, then read 0x10 → PREADY on the 2nd cycle of each transfer, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-036 WAIT_STATES=3: read 0x10 → PREADY=1 exactly on the 5th cycle; PREADY=0 on the 2nd–4th cycles.
REQ-037 Write 0x11223344, then write 0xAABBCCDD with PSTRB=0b0101 to the same address, read → 0x11BB33DD.
REQ-038 Write to 0x100 (DEPTH=64) or 0x12 → PSLVERR=1 with PREADY; reading 0x100 returns PRDATA=0; memory is unchanged.
REQ-039 Back-to-back writes to 0x0/0x4/0x8 without an IDLE cycle complete in 6 cycles total, and readback is correct.
REQ-040 Cases: PSEL dropped in WAIT (WAIT_STATES=2), and PRESET asserted in WAIT → no write, PREADY stays 0, next transfer completes normally.
